// File: rtl/not_not_judge.sv
// -----------------------------------------------------------------------------
// not_not_judge
//   Player-response side of a Not Not round. Requests a prompt (a 4-bit mask of
//   acceptable colour switches), opens a timed answer window, judges the
//   player's switch/KEY response against the mask, keeps score and lives, and
//   reports each round result for the display logic.
//
// Ports:
//   clock          in   system clock
//   resetn         in   synchronous active-low reset
//   start          in   leaves IDLE / GAME_OVER when high
//   prompt_valid   in   prompt generator has a prompt ready
//   expected_mask  in   [3:0] acceptable switches, 0 means "touch nothing"
//   req_next       out  high while waiting for a prompt
//   sw             in   [3:0] raw player switches (asynchronous)
//   submit_n       in   raw KEY, active-low (asynchronous)
//   round_active   out  high during the answer window
//   round_done     out  one-cycle pulse when a round is judged
//   result_correct out  verdict of the last judged round
//   score          out  [7:0] correct answers, saturating at 255
//   lives          out  [2:0] remaining lives
//   game_over      out  high in GAME_OVER
// -----------------------------------------------------------------------------
module not_not_judge #(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int RESULT_CYCLES  = 25000000,
  parameter int LIVES          = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       prompt_valid,
  input  logic [3:0] expected_mask,
  output logic       req_next,
  input  logic [3:0] sw,
  input  logic       submit_n,
  output logic       round_active,
  output logic       round_done,
  output logic       result_correct,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int MAX_CYCLES = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RESULT_LAST  = TW'(RESULT_CYCLES - 1);
  localparam logic [2:0]    LIVES_INIT   = 3'(LIVES);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PROMPT,
    ANSWER,
    RESULT,
    GAME_OVER
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    mask_q;

  // Input synchronizers and press edge detector.
  logic [3:0] sw_s1, sw_s2;
  logic       sub_s1, sub_s2, sub_d;
  logic       press;

  // NOTE: the reset branch lives inside the clocked block and resetn is not in
  // the sensitivity list, so reset only takes effect on a clock edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sw_s1  <= 4'b0000;
      sw_s2  <= 4'b0000;
      sub_s1 <= 1'b1;
      sub_s2 <= 1'b1;
      sub_d  <= 1'b1;
      press  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its predecessor, which is what turns this chain into a shift register.
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      sub_s1 <= submit_n;
      sub_s2 <= sub_s1;
      sub_d  <= sub_s2;
      // Registered 1->0 edge of the synchronized key: one pulse per press,
      // so a key held down across rounds never re-triggers.
      press  <= sub_d & ~sub_s2;
    end
  end

  // Exactly one switch up and inside the mask, or nothing when mask is empty.
  function automatic logic judge(input logic [3:0] ans, input logic [3:0] mask);
    logic one_hot;
    one_hot = (ans != 4'b0000) && ((ans & (ans - 4'd1)) == 4'b0000);
    return (one_hot && ((ans & mask) != 4'b0000)) || (ans == 4'b0000 && mask == 4'b0000);
  endfunction

  // A press wins over a coincident timeout; a timeout judges "did nothing".
  logic       timeout_hit;
  logic [3:0] answer;
  logic       verdict;

  assign timeout_hit = (timer == TIMEOUT_LAST);
  assign answer      = press ? sw_s2 : 4'b0000;
  assign verdict     = judge(answer, mask_q);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= IDLE;
      timer          <= '0;
      mask_q         <= 4'b0000;
      req_next       <= 1'b0;
      round_active   <= 1'b0;
      round_done     <= 1'b0;
      result_correct <= 1'b0;
      score          <= 8'd0;
      lives          <= LIVES_INIT;
      game_over      <= 1'b0;
    end else begin
      round_done <= 1'b0;
      unique case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            score     <= 8'd0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
            req_next  <= 1'b1;
            state     <= WAIT_PROMPT;
          end
        end
        WAIT_PROMPT: begin
          if (prompt_valid) begin
            mask_q       <= expected_mask;
            timer        <= '0;
            req_next     <= 1'b0;
            round_active <= 1'b1;
            state        <= ANSWER;
          end
        end
        ANSWER: begin
          if (press || timeout_hit) begin
            round_done     <= 1'b1;
            result_correct <= verdict;
            round_active   <= 1'b0;
            timer          <= '0;
            state          <= RESULT;
            if (verdict) begin
              if (score != 8'hFF) score <= score + 8'd1;
            end else begin
              lives <= lives - 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESULT: begin
          if (timer == RESULT_LAST) begin
            timer <= '0;
            if (lives == 3'd0) begin
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else begin
              req_next <= 1'b1;
              state    <= WAIT_PROMPT;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
